// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - push-button synchroniser, debouncer and press/release/repeat event generator
// Auto-repeat logic is present only when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
    parameter int N_BTN        = 5,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             evt_valid,
    output logic [2:0]       evt_code
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;
    logic [DB_W-1:0]  db_cnt [N_BTN];
    logic [N_BTN-1:0] level_nxt;
    logic [N_BTN-1:0] evt_bits;

    // Level flips on the edge the counter has seen DEBOUNCE_CYC consecutive differing samples.
    always_comb begin
        level_nxt = btn_level;
        for (int i = 0; i < N_BTN; i++) begin
            if ((s2[i] != btn_level[i]) && (db_cnt[i] == DB_LAST)) begin
                level_nxt[i] = ~btn_level[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s1          <= btn_raw;
            s2          <= s1;
            btn_level   <= level_nxt;
            btn_press   <= level_nxt & ~btn_level;
            btn_release <= ~level_nxt & btn_level;
            for (int i = 0; i < N_BTN; i++) begin
                if ((s2[i] == btn_level[i]) || (db_cnt[i] == DB_LAST)) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
    localparam logic [RP_W-1:0] RP_DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_RATE_LAST  = RP_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    rep_state_t      rep_state [N_BTN];
    logic [RP_W-1:0] rep_cnt   [N_BTN];

    // Press and release are taken from level_nxt so the FSM moves in the same cycle as the pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_repeat <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                rep_state[i] <= IDLE;
                rep_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                btn_repeat[i] <= 1'b0;
                if (level_nxt[i] && !btn_level[i]) begin
                    rep_state[i] <= DELAY;
                    rep_cnt[i]   <= '0;
                end else if (!level_nxt[i]) begin
                    rep_state[i] <= IDLE;
                    rep_cnt[i]   <= '0;
                end else begin
                    case (rep_state[i])
                        DELAY: begin
                            if (rep_cnt[i] == RP_DELAY_LAST) begin
                                btn_repeat[i] <= 1'b1;
                                rep_cnt[i]    <= '0;
                                rep_state[i]  <= REPEAT;
                            end else begin
                                rep_cnt[i] <= rep_cnt[i] + RP_W'(1);
                            end
                        end
                        REPEAT: begin
                            if (rep_cnt[i] == RP_RATE_LAST) begin
                                btn_repeat[i] <= 1'b1;
                                rep_cnt[i]    <= '0;
                            end else begin
                                rep_cnt[i] <= rep_cnt[i] + RP_W'(1);
                            end
                        end
                        default: begin
                            rep_cnt[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end
`else
    assign btn_repeat = '0;
`endif

    // Lowest index wins; the rest remain visible only in the vectors.
    always_comb begin
        evt_bits  = btn_press | btn_repeat;
        evt_valid = |evt_bits;
        evt_code  = 3'd0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (evt_bits[i]) begin
                evt_code = 3'(i);
            end
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - randomized self-checking bench for btn_conditioner against a behavioural model
`timescale 1ns/1ps
module tb_btn_conditioner;

    localparam int N   = 5;
    localparam int DEB = 8;
    localparam int RD  = 20;
    localparam int RR  = 5;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;
    logic         evt_valid;
    logic [2:0]   evt_code;
    logic [23:0]  dut_vec;

    btn_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .evt_valid(evt_valid), .evt_code(evt_code)
    );

    always #5 clk = ~clk;

    assign dut_vec = {btn_level, btn_press, btn_release, btn_repeat, evt_valid, evt_code};

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: s2 history window, level flips after DEB consecutive differing samples,
    // repeats scheduled arithmetically from the press cycle.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_press = '0, m_rel = '0, m_rep = '0;
    logic         m_valid = 1'b0;
    logic [2:0]   m_code = '0;
    logic [N-1:0] hist[$];
    int           press_cyc[N];

    function automatic logic [23:0] model_vec();
        return {m_level, m_press, m_rel, m_rep, m_valid, m_code};
    endfunction

    task automatic step();
        logic [N-1:0] old_level;
        logic [N-1:0] ev;
        bit           flip;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_rep = '0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > DEB) void'(hist.pop_front());
            m_s2 = m_s1;
            m_s1 = btn_raw;
            old_level = m_level;
            for (int i = 0; i < N; i++) begin
                flip = (hist.size() == DEB);
                foreach (hist[j]) if (hist[j][i] == old_level[i]) flip = 1'b0;
                if (flip) m_level[i] = ~old_level[i];
            end
            m_press = m_level & ~old_level;
            m_rel   = old_level & ~m_level;
            m_rep   = '0;
            for (int i = 0; i < N; i++) begin
                if (m_press[i]) press_cyc[i] = cyc;
                else if (AUTOREP && m_level[i] && (cyc - press_cyc[i] >= RD) &&
                         ((cyc - press_cyc[i] - RD) % RR == 0)) m_rep[i] = 1'b1;
            end
        end
        ev = m_press | m_rep;
        m_valid = |ev;
        m_code = 3'd0;
        for (int i = N - 1; i >= 0; i--) if (ev[i]) m_code = 3'(i);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_raw = 5'($urandom);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (dut_vec !== 24'd0) begin
                failures++;
                $display("FAIL reset_outputs k=%0d got=%h want=000000", k, dut_vec);
            end
        end
        btn_raw = '0;
        rst = 1'b0;
        repeat (DEB + 4) step();
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL reset_settle got=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_clean_press();
        btn_raw = '0;
        repeat (4) step();
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            checks++;
            if (btn_level[2] !== (k >= 10) || btn_press[2] !== (k == 10) ||
                evt_valid !== (k == 10) || evt_code !== ((k == 10) ? 3'd2 : 3'd0)) begin
                failures++;
                $display("FAIL clean_press k=%0d got lvl=%b prs=%b vld=%b code=%0d want lvl=%b prs=%b code=%0d",
                         k, btn_level[2], btn_press[2], evt_valid, evt_code, (k >= 10), (k == 10), (k == 10) ? 2 : 0);
            end
        end
        btn_raw[2] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (btn_release[2] !== (k == 10) || btn_level[2] !== (k < 10)) begin
                failures++;
                $display("FAIL clean_release k=%0d got rel=%b lvl=%b want rel=%b lvl=%b",
                         k, btn_release[2], btn_level[2], (k == 10), (k < 10));
            end
        end
    endtask

    task automatic test_glitch();
        logic [N-1:0] pattern[$];
        pattern.delete();
        repeat (7) pattern.push_back(5'b00001);
        repeat (12) pattern.push_back(5'b00000);
        repeat (5) pattern.push_back(5'b00001);
        pattern.push_back(5'b00000);
        repeat (6) pattern.push_back(5'b00001);
        repeat (12) pattern.push_back(5'b00000);
        foreach (pattern[k]) begin
            btn_raw = pattern[k];
            step();
            checks++;
            if (btn_level[0] !== 1'b0 || btn_press[0] !== 1'b0 || evt_valid !== 1'b0) begin
                failures++;
                $display("FAIL glitch k=%0d got lvl=%b prs=%b vld=%b want 0 0 0",
                         k, btn_level[0], btn_press[0], evt_valid);
            end
        end
    endtask

    task automatic test_autorepeat();
        bit found = 1'b0;
        bit exp_rep;
        btn_raw = '0;
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (btn_press[1]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL autorepeat_press got=none want=press within 20 cycles");
        end
        for (int off = 1; off <= 50; off++) begin
            step();
            exp_rep = AUTOREP && (off == 20 || off == 25 || off == 30 || off == 35 || off == 40);
            checks++;
            if (btn_repeat[1] !== exp_rep || btn_release[1] !== (off == 42) || btn_press[1] !== 1'b0 ||
                evt_valid !== exp_rep || evt_code !== (exp_rep ? 3'd1 : 3'd0)) begin
                failures++;
                $display("FAIL autorepeat off=%0d got rep=%b rel=%b prs=%b vld=%b code=%0d want rep=%b rel=%b",
                         off, btn_repeat[1], btn_release[1], btn_press[1], evt_valid, evt_code, exp_rep, (off == 42));
            end
            if (off == 32) btn_raw[1] = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        bit found = 1'b0;
        btn_raw = 5'b01010;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (btn_press != 0) found = 1'b1;
        end
        checks++;
        if (!found || btn_press !== 5'b01010 || evt_valid !== 1'b1 || evt_code !== 3'd1) begin
            failures++;
            $display("FAIL simultaneous found=%b got prs=%b vld=%b code=%0d want prs=01010 vld=1 code=1",
                     found, btn_press, evt_valid, evt_code);
        end
        btn_raw = '0;
        repeat (30) step();
    endtask

    task automatic test_reset_mid();
        btn_raw = 5'b10000;
        repeat (5) step();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (dut_vec !== 24'd0) begin
                failures++;
                $display("FAIL reset_mid_during k=%0d got=%h want=000000", k, dut_vec);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if ((k == 1 && dut_vec !== 24'd0) || btn_press[4] !== (k == 10)) begin
                failures++;
                $display("FAIL reset_mid_after k=%0d got vec=%h prs4=%b want prs4=%b", k, dut_vec, btn_press[4], (k == 10));
            end
        end
        btn_raw = '0;
        repeat (15) step();
    endtask

    task automatic test_long_hold();
        int n_press = 0, n_rel = 0, n_rep = 0;
        btn_raw = 5'b00010;
        for (int k = 0; k < 120; k++) begin
            if (k == 100) btn_raw = '0;
            step();
            n_press += int'(btn_press[1]);
            n_rel   += int'(btn_release[1]);
            n_rep   += int'(btn_repeat[1]);
        end
        checks++;
        if (n_press != 1 || n_rel != 1 || n_rep != (AUTOREP ? 16 : 0)) begin
            failures++;
            $display("FAIL long_hold got press=%0d release=%0d repeat=%0d want 1 1 %0d",
                     n_press, n_rel, n_rep, AUTOREP ? 16 : 0);
        end
    endtask

    task automatic test_random();
        int hold[N];
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 30);
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DEB) : $urandom_range(DEB, 60);
                end
            end
            rst = ($urandom_range(0, 499) == 0);
            step();
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL random k=%0d raw=%b got=%h want=%h", k, btn_raw, dut_vec, model_vec());
            end
        end
        rst = 1'b0;
        btn_raw = '0;
        repeat (20) step();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_autorepeat();
        test_simultaneous();
        test_reset_mid();
        test_long_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
